// File: rtl/iter_div_unit.sv
// -----------------------------------------------------------------------------
// iter_div_unit
//
// Iterative radix-2 restoring divider for signed (div.w/mod.w) and unsigned
// (div.wu/mod.wu) operands. One quotient bit is produced per clock. A one-cycle
// FIX stage applies the result signs. Divide-by-zero and signed overflow
// bypass the iteration and complete right after accept.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high reset
//   in_valid     request present
//   in_ready     unit can accept a request (IDLE and no flush)
//   in_signed    1 = signed operation, 0 = unsigned
//   in_dividend  dividend, WIDTH bits
//   in_divisor   divisor, WIDTH bits
//   flush        synchronous abort of any in-flight operation or held result
//   out_valid    result present (DONE state)
//   out_ready    consumer takes the result
//   out_quot     quotient, WIDTH bits
//   out_rem      remainder, WIDTH bits (sign follows the dividend)
//   busy         unit is in any state other than IDLE
// -----------------------------------------------------------------------------
module iter_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t state, state_nxt;

    // Iteration registers: partial remainder, dividend/quotient shift register,
    // divisor magnitude, step counter and the sign fix-up flags.
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    // Request decode
    logic             accept;
    logic             dd_neg;
    logic             dv_neg;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] dd_mag;
    logic [WIDTH-1:0] dv_mag;

    // One restoring step
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   trial_sub;
    logic             trial_ge;

    assign in_ready  = (state == IDLE) && !flush;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    assign accept   = in_valid && in_ready;
    assign dd_neg   = in_signed && in_dividend[WIDTH-1];
    assign dv_neg   = in_signed && in_divisor[WIDTH-1];
    assign div_zero = (in_divisor == '0);
    assign div_ovf  = in_signed && (in_dividend == MOST_NEG) && (in_divisor == '1);

    // Magnitude of the most-negative value is 2^(WIDTH-1), which still fits
    // in WIDTH bits when read as unsigned.
    assign dd_mag = dd_neg ? (~in_dividend + 1'b1) : in_dividend;
    assign dv_mag = dv_neg ? (~in_divisor + 1'b1) : in_divisor;

    // Shift in the next dividend bit (MSB of the shift register). The partial
    // remainder is always below the divisor, so one extra bit is enough.
    assign trial     = {rem_q, quo_q[WIDTH-1]};
    assign trial_ge  = (trial >= {1'b0, dvs_q});
    assign trial_sub = trial - {1'b0, dvs_q};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next-state is given a default before the case so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (div_zero || div_ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == LAST_STEP) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Abort wins over everything; a result held in DONE is discarded, or
        // consumed if out_ready is also high -- both end in IDLE.
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            out_quot  <= '0;
            out_rem   <= '0;
        end else if (accept) begin
            rem_q     <= '0;
            quo_q     <= dd_mag;
            dvs_q     <= dv_mag;
            cnt_q     <= '0;
            neg_quo_q <= dd_neg ^ dv_neg;
            neg_rem_q <= dd_neg;
            // Special cases finish straight from IDLE, so their results are
            // registered here rather than in FIX.
            if (div_zero) begin
                out_quot <= '1;
                out_rem  <= in_dividend;
            end else if (div_ovf) begin
                out_quot <= MOST_NEG;
                out_rem  <= '0;
            end
        end else if (state == CALC) begin
            rem_q <= trial_ge ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], trial_ge};
            cnt_q <= cnt_q + 1'b1;
        end else if ((state == FIX) && !flush) begin
            out_quot <= neg_quo_q ? (~quo_q + 1'b1) : quo_q;
            out_rem  <= neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        end
    end

endmodule

// File: tb/tb_iter_div_unit.sv
// -----------------------------------------------------------------------------
// tb_iter_div_unit
//
// Self-checking bench for iter_div_unit (WIDTH = 32). Expected quotient,
// remainder and latency come from an arithmetic reference model using 64-bit
// integer division. Latency is counted in rising edges from the cycle the
// request is presented (the accept edge is edge 1).
// -----------------------------------------------------------------------------
module tb_iter_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         in_signed;
    logic [W-1:0] in_dividend;
    logic [W-1:0] in_divisor;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quot;
    logic [W-1:0] out_rem;
    logic         busy;

    int checks = 0;
    int errors = 0;

    iter_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .in_dividend (in_dividend),
        .in_divisor  (in_divisor),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_quot    (out_quot),
        .out_rem     (out_rem),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: plain integer division with the special cases.
    task automatic ref_div(input logic sgn, input logic [W-1:0] dd, input logic [W-1:0] dv,
                           output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
        longint a;
        longint b;
        if (dv == 0) begin
            q   = '1;
            r   = dd;
            lat = 1;
        end else if (sgn && dd == 32'h8000_0000 && dv == 32'hFFFF_FFFF) begin
            q   = 32'h8000_0000;
            r   = '0;
            lat = 1;
        end else begin
            if (sgn) begin
                a = longint'($signed(dd));
                b = longint'($signed(dv));
            end else begin
                a = longint'({32'h0, dd});
                b = longint'({32'h0, dv});
            end
            q   = W'(a / b);
            r   = W'(a % b);
            lat = W + 2;
        end
    endtask

    // Present one request, check latency/result, hold the result for `hold`
    // cycles of backpressure with toggling inputs, then release it.
    task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] dd,
                          input logic [W-1:0] dv, input int hold);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int           elat;
        int           n;
        ref_div(sgn, dd, dv, eq, er, elat);

        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s ready", tag), in_ready, 1'b1);

        in_valid    = 1'b1;
        in_signed   = sgn;
        in_dividend = dd;
        in_divisor  = dv;
        out_ready   = (hold == 0);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                // Operands must have been captured on the accept edge only.
                in_valid    = 1'b0;
                in_signed   = 1'($urandom_range(0, 1));
                in_dividend = 32'($urandom);
                in_divisor  = 32'($urandom);
            end
        end while (!out_valid && n < 200);

        check($sformatf("%s latency", tag), 64'(n), 64'(elat));
        check($sformatf("%s quot", tag), out_quot, eq);
        check($sformatf("%s rem", tag), out_rem, er);
        check($sformatf("%s busy in DONE", tag), busy, 1'b1);
        check($sformatf("%s in_ready in DONE", tag), in_ready, 1'b0);

        for (int i = 0; i < hold; i++) begin
            in_valid    = 1'($urandom_range(0, 1));
            in_signed   = 1'($urandom_range(0, 1));
            in_dividend = 32'($urandom);
            in_divisor  = 32'($urandom);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s hold%0d valid", tag, i), out_valid, 1'b1);
            check($sformatf("%s hold%0d quot", tag, i), out_quot, eq);
            check($sformatf("%s hold%0d rem", tag, i), out_rem, er);
            check($sformatf("%s hold%0d in_ready", tag, i), in_ready, 1'b0);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check($sformatf("%s valid after handshake", tag), out_valid, 1'b0);
        check($sformatf("%s busy after handshake", tag), busy, 1'b0);
        check($sformatf("%s in_ready after handshake", tag), in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("%s single handshake", tag), out_valid, 1'b0);
    endtask

    initial begin : stim
        int          seen;
        logic        sgn;
        logic [W-1:0] dd;
        logic [W-1:0] dv;

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_signed   = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset out_valid", out_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset quot", out_quot, 32'h0);
        check("reset rem", out_rem, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("reset in_ready", in_ready, 1'b1);

        // Directed operations
        run_op("u7/2", 1'b0, 32'd7, 32'd2, 0);
        run_op("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        run_op("u div0", 1'b0, 32'h1234, 32'h0, 0);
        run_op("s div0", 1'b1, 32'h1234, 32'h0, 0);
        run_op("s ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("u minneg/ones", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("u max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("s minneg/3", 1'b1, 32'h8000_0000, 32'd3, 0);
        run_op("backpressure", 1'b1, 32'hFFFF_CFC7, 32'd67, 10);

        // Flush during CALC cycle 5 with a competing request
        in_valid    = 1'b1;
        in_signed   = 1'b0;
        in_dividend = 32'hFFFF_FFFF;
        in_divisor  = 32'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("flush busy before", busy, 1'b1);
        flush       = 1'b1;
        in_valid    = 1'b1;
        in_dividend = 32'd5;
        in_divisor  = 32'd1;
        #1;
        check("flush in_ready calc", in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("flush to idle", busy, 1'b0);
        check("flush no valid", out_valid, 1'b0);
        check("flush blocks in_ready", in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("flush no accept", busy, 1'b0);
        flush    = 1'b0;
        in_valid = 1'b0;
        seen = 0;
        repeat (W + 5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush no stale result", 64'(seen), 64'd0);
        run_op("after flush 100/7", 1'b0, 32'd100, 32'd7, 0);

        // Asynchronous reset mid-CALC
        in_valid    = 1'b1;
        in_signed   = 1'b0;
        in_dividend = 32'd1000;
        in_divisor  = 32'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset valid", out_valid, 1'b0);
        check("async reset busy", busy, 1'b0);
        check("async reset quot", out_quot, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post reset in_ready", in_ready, 1'b1);
        seen = 0;
        repeat (W + 5) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        check("post reset no result", 64'(seen), 64'd0);

        // Randomized operations including special operand values
        for (int k = 0; k < 40; k++) begin
            sgn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       dv = 32'h0;
                1:       dv = 32'hFFFF_FFFF;
                2:       dv = 32'($urandom_range(1, 15));
                default: dv = 32'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       dd = 32'h8000_0000;
                1:       dd = 32'($urandom_range(0, 255));
                default: dd = 32'($urandom);
            endcase
            run_op($sformatf("rand%0d", k), sgn, dd, dv, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
